// File: rtl/noise_cdf_gen.sv
// Inverse-CDF noise generator: pipelined binary search of a runtime-loaded
// cumulative-probability table, with valid/ready flow control and saturating bin histograms.
module noise_cdf_gen #(
    parameter int NBINS  = 128,
    parameter int PW     = 64,
    parameter int OW     = 8,
    parameter int OFFSET = 63,
    parameter int HCW    = 16,
    localparam int AW    = $clog2(NBINS)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            tbl_we,
    input  logic [AW-1:0]   tbl_addr,
    input  logic [PW-1:0]   tbl_data,
    output logic            tbl_full,
    input  logic            tbl_clr,
    input  logic            cfg_start,
    input  logic            cfg_stop,
    output logic            running,
    input  logic [PW-1:0]   rnd_in,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    output logic [OW-1:0]   noise_out,
    output logic            noise_valid,
    input  logic            noise_ready,
    output logic [HCW-1:0]  miss_cnt,
    input  logic [AW-1:0]   hist_addr,
    output logic [HCW-1:0]  hist_data,
    input  logic            hist_clr
);

    typedef enum logic {LOAD, RUN} state_t;

    typedef struct packed {
        logic          v;
        logic [PW-1:0] rnd;
        logic [AW-1:0] pos;
    } stage_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   tbl [NBINS];
    logic [NBINS-1:0] mask;
    logic [HCW-1:0]  hist [NBINS];
    stage_t          st_q [AW+1];
    stage_t          st_d [AW+1];
    logic [AW-1:0]   out_bin;
    logic            advance, accept, flush, miss, emit, out_hs;

    assign running   = (state_q == RUN);
    assign advance   = !noise_valid || noise_ready;
    assign rnd_ready = running && advance;
    assign accept    = rnd_valid && rnd_ready;
    assign flush     = running && cfg_stop;
    assign miss      = tbl[NBINS-1] <= st_q[AW].rnd;
    assign emit      = st_q[AW].v && !miss;
    assign out_hs    = noise_valid && noise_ready;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= LOAD;
        else       state_q <= state_d;
    end

    // NOTE: combinational blocks assign every output a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (cfg_start && tbl_full && !cfg_stop) state_d = RUN;
            RUN:     if (cfg_stop) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // ---------------- table and written-mask ----------------
    // NOTE: the table is pure storage and carries no reset; only the mask that
    // says which entries are trustworthy is reset.
    always_ff @(posedge clk) begin
        if (tbl_we && !running) tbl[tbl_addr] <= tbl_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask     <= '0;
            tbl_full <= 1'b0;
        end else begin
            if (!running) begin
                if (tbl_clr) mask <= '0;
                if (tbl_we)  mask[tbl_addr] <= 1'b1;
            end
            tbl_full <= &mask;
        end
    end

    // ---------------- binary search pipeline ----------------
    // Stage k decides bit AW-k of the bin index: cdf[pos | (2^b - 1)] <= rnd
    // means the answer lies in the upper half of the remaining window.
    // NOTE: blocking '=' is used only in combinational blocks; every register
    // below is written with non-blocking '<=' so stages shift in lockstep.
    always_comb begin
        for (int k = 0; k <= AW; k++) st_d[k] = '0;
        st_d[0].v   = accept;
        st_d[0].rnd = rnd_in;
        for (int k = 1; k <= AW; k++) begin
            st_d[k] = st_q[k-1];
            if (tbl[st_q[k-1].pos | AW'((1 << (AW - k)) - 1)] <= st_q[k-1].rnd)
                st_d[k].pos = st_q[k-1].pos | AW'(1 << (AW - k));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k <= AW; k++) st_q[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k <= AW; k++) st_q[k] <= '0;
        end else if (advance) begin
            for (int k = 0; k <= AW; k++) st_q[k] <= st_d[k];
        end
    end

    // Output register: a miss consumes the word without producing a sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            noise_out   <= '0;
            noise_valid <= 1'b0;
            out_bin     <= '0;
        end else if (flush) begin
            noise_valid <= 1'b0;
        end else if (advance) begin
            noise_valid <= emit;
            if (emit) begin
                noise_out <= OW'(st_q[AW].pos) - OW'(OFFSET);
                out_bin   <= st_q[AW].pos;
            end
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            miss_cnt <= '0;
        end else if (hist_clr) begin
            miss_cnt <= '0;
        end else if (!flush && advance && st_q[AW].v && miss && miss_cnt != '1) begin
            miss_cnt <= miss_cnt + HCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NBINS; i++) hist[i] <= '0;
            hist_data <= '0;
        end else begin
            if (hist_clr) begin
                for (int i = 0; i < NBINS; i++) hist[i] <= '0;
            end else if (out_hs && hist[out_bin] != '1) begin
                hist[out_bin] <= hist[out_bin] + HCW'(1);
            end
            hist_data <= hist[hist_addr];
        end
    end

endmodule

// File: tb/tb_noise_cdf_gen.sv
// Directed self-checking bench for noise_cdf_gen with an 8-bin, 16-bit table
// holding cdf[i] = 1000*(i+1), so the expected bin of a word is rnd/1000.
module tb_noise_cdf_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tbl_we, tbl_clr, cfg_start, cfg_stop;
    logic [2:0]  tbl_addr, hist_addr;
    logic [15:0] tbl_data, rnd_in;
    logic        tbl_full, running, rnd_valid, rnd_ready;
    logic [7:0]  noise_out;
    logic        noise_valid, noise_ready, hist_clr;
    logic [3:0]  miss_cnt, hist_data;

    int tests = 0;
    int fails = 0;

    noise_cdf_gen #(.NBINS(8), .PW(16), .OW(8), .OFFSET(3), .HCW(4)) dut (
        .clk(clk), .rstn(rstn),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .tbl_full(tbl_full), .tbl_clr(tbl_clr),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .running(running),
        .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .noise_out(noise_out), .noise_valid(noise_valid), .noise_ready(noise_ready),
        .miss_cnt(miss_cnt), .hist_addr(hist_addr), .hist_data(hist_data),
        .hist_clr(hist_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input int a, input int d);
        tbl_we   = 1'b1;
        tbl_addr = 3'(a);
        tbl_data = 16'(d);
        tick();
        tbl_we   = 1'b0;
    endtask

    initial begin
        int          words [4];
        logic [7:0]  exp_out [4];
        logic [7:0]  expq [$];
        logic [7:0]  held;
        logic        stalled, seen, acc, hs;
        int          sent, got, cyc, n;

        words   = '{0, 999, 1000, 7999};
        exp_out = '{8'hFD, 8'hFD, 8'hFE, 8'h04};

        rstn = 1'b0; tbl_we = 0; tbl_clr = 0; cfg_start = 0; cfg_stop = 0;
        tbl_addr = 0; tbl_data = 0; rnd_in = 0; rnd_valid = 0;
        noise_ready = 0; hist_addr = 0; hist_clr = 0;
        tick(); tick();

        // Reset values
        check("rst_noise_out",   noise_out,   0);
        check("rst_noise_valid", noise_valid, 0);
        check("rst_rnd_ready",   rnd_ready,   0);
        check("rst_running",     running,     0);
        check("rst_tbl_full",    tbl_full,    0);
        check("rst_miss_cnt",    miss_cnt,    0);
        check("rst_hist_data",   hist_data,   0);
        #2 rstn = 1'b1;
        tick();

        // Start gating with an incomplete table
        for (int i = 0; i < 7; i++) write_tbl(i, 1000 * (i + 1));
        tick(); tick();
        check("partial_tbl_full", tbl_full, 0);
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        tick();
        check("start_gated", running, 0);

        write_tbl(7, 8000);
        tick();
        check("tbl_full_set", tbl_full, 1);
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        check("start_ok", running, 1);

        // Miss: rnd equal to the last CDF entry
        noise_ready = 1'b1;
        rnd_in = 16'd8000; rnd_valid = 1'b1;
        #1 check("rdy_in_run", rnd_ready, 1);
        tick();
        rnd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= noise_valid;
        end
        check("miss_no_valid", seen, 0);
        check("miss_cnt_one", miss_cnt, 1);

        // Load-and-run latency and values
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                rnd_in = 16'(words[c]); rnd_valid = 1'b1;
            end else begin
                rnd_valid = 1'b0;
            end
            tick();
            if (c >= 4 && c < 8) begin
                check("lat_valid", noise_valid, 1);
                check("lat_data",  noise_out,   exp_out[c-4]);
            end else begin
                check("lat_idle", noise_valid, 0);
            end
        end

        // Backpressure: random noise_ready, order and hold checked
        sent = 0; got = 0; cyc = 0;
        while (got < 20 && cyc < 400) begin
            noise_ready = 1'($urandom_range(0, 1));
            rnd_valid   = (sent < 20);
            rnd_in      = 16'((sent * 397 + 123) % 8000);
            #1;
            acc     = rnd_valid && rnd_ready;
            hs      = noise_valid && noise_ready;
            stalled = noise_valid && !noise_ready;
            held    = noise_out;
            if (stalled) check("bp_stall_rdy", rnd_ready, 0);
            if (hs) begin
                if (expq.size() == 0) check("bp_extra", 1, 0);
                else check("bp_data", noise_out, expq.pop_front());
                got++;
            end
            if (acc) begin
                expq.push_back(8'(int'(rnd_in) / 1000 - 3));
                sent++;
            end
            tick();
            cyc++;
            if (stalled) begin
                check("bp_stall_hold",  noise_out,   held);
                check("bp_stall_valid", noise_valid, 1);
            end
        end
        check("bp_count", got, 20);
        rnd_valid = 1'b0; noise_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("bp_drained", noise_valid, 0);

        // Histogram saturation on bin 2
        hist_clr = 1'b1; tick(); hist_clr = 1'b0;
        hist_addr = 3'd2;
        for (int i = 0; i < 20; i++) begin
            rnd_in = 16'd2500; rnd_valid = 1'b1;
            tick();
        end
        rnd_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("hist_sat", hist_data, 15);
        check("miss_cleared", miss_cnt, 0);
        hist_addr = 3'd3; tick(); tick();
        check("hist_other_bin", hist_data, 0);
        hist_addr = 3'd2;

        // hist_clr coinciding with an accepted bin-2 sample
        rnd_in = 16'd2500; rnd_valid = 1'b1; tick(); rnd_valid = 1'b0;
        n = 0;
        while (!noise_valid && n < 10) begin
            tick();
            n++;
        end
        check("clr_wait_valid", noise_valid, 1);
        hist_clr = 1'b1; tick(); hist_clr = 1'b0;
        tick(); tick();
        check("clr_wins", hist_data, 0);

        // cfg_stop with three samples in flight
        for (int i = 0; i < 3; i++) begin
            rnd_in = 16'd500; rnd_valid = 1'b1;
            tick();
        end
        rnd_valid = 1'b0; cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
        check("stop_running", running, 0);
        check("stop_valid", noise_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= noise_valid;
        end
        check("stop_no_output", seen, 0);
        hist_addr = 3'd0; tick(); tick();
        check("stop_hist", hist_data, 0);
        check("stop_miss", miss_cnt, 0);

        // Asynchronous reset in the middle of a stalled run
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        noise_ready = 1'b0;
        rnd_in = 16'd9000; rnd_valid = 1'b1; tick();
        rnd_in = 16'd1500; tick();
        rnd_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_valid", noise_valid, 1);
        check("pre_rst_data",  noise_out,   8'hFE);
        check("pre_rst_miss",  miss_cnt,    1);
        check("pre_rst_rdy",   rnd_ready,   0);
        #2 rstn = 1'b0;
        #1;
        check("arst_noise_out",   noise_out,   0);
        check("arst_noise_valid", noise_valid, 0);
        check("arst_running",     running,     0);
        check("arst_tbl_full",    tbl_full,    0);
        check("arst_miss_cnt",    miss_cnt,    0);
        check("arst_hist_data",   hist_data,   0);
        check("arst_rnd_ready",   rnd_ready,   0);
        #2 rstn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
